// File: rtl/core_test_ctrl_pkg.sv
// Shared types and default run parameters for the riscv-tests run controller.
package core_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] HALT_PC_DEF = 32'h44;
    localparam logic [31:0] PASS_GP_DEF = 32'h1;
    localparam int          TIMEOUT_DEF = 5000;

endpackage

// File: rtl/core_test_ctrl_if.sv
// Host load handshake plus the registered memory write port it feeds.
interface core_test_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output load_valid, load_addr, load_data,
        input  load_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  load_valid, load_addr, load_data,
        output load_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/core_test_ctrl_load_port.sv
// Registers accepted host writes onto the memory write port; only open while enabled.
module ctrl_load_port #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              accept;

    assign load_ready = en;
    assign accept     = load_valid && en;

    always_comb begin
        mem_we_d    = accept;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (accept) begin
            mem_addr_d  = load_addr;
            mem_wdata_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: rtl/core_test_ctrl.sv
// Run controller: loads the program while the core is in reset, releases it, then
// ends the run on halt pc (pass/fail by gp) or on a RUN-cycle timeout.
module core_test_ctrl
    import core_test_pkg::*;
#(
    parameter logic [31:0] HALT_PC    = HALT_PC_DEF,
    parameter logic [31:0] PASS_GP    = PASS_GP_DEF,
    parameter int          TIMEOUT    = TIMEOUT_DEF,
    parameter int          RST_CYCLES = 2,
    parameter int          ADDR_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    core_test_ctrl_if.slave    bus,
    output logic               core_rst,
    input  logic [31:0]        core_pc,
    input  logic [31:0]        core_gp,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [31:0]        cycles
);

    localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] rst_cnt_q, rst_cnt_d;
    logic [31:0] cycles_q, cycles_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        load_en;

    assign load_en = (state_q == ST_IDLE) || (state_q == ST_DONE);

    ctrl_load_port #(.ADDR_W(ADDR_W)) u_load_port (
        .clk        (clk),
        .rst        (rst),
        .en         (load_en),
        .load_valid (bus.load_valid),
        .load_addr  (bus.load_addr),
        .load_data  (bus.load_data),
        .load_ready (bus.load_ready),
        .mem_we     (bus.mem_we),
        .mem_addr   (bus.mem_addr),
        .mem_wdata  (bus.mem_wdata)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cycles_d  = cycles_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d  = ST_RUN;
                    cycles_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            ST_RUN: begin
                // Halt is checked first so a halt on the last budgeted cycle still counts.
                if (core_pc == HALT_PC) begin
                    state_d   = ST_DONE;
                    pass_d    = (core_gp == PASS_GP);
                    timeout_d = 1'b0;
                end else if (cycles_q == TIMEOUT_LAST) begin
                    state_d   = ST_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rst_cnt_q <= '0;
            cycles_q  <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cycles_q  <= cycles_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign core_rst = (state_q != ST_RUN);
    assign busy     = (state_q == ST_RESET) || (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_core_test_ctrl.sv
// Directed bench for core_test_ctrl: write and run-result scoreboards, one instance
// with the default timeout and one with a short timeout.
module tb_core_test_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          due;
    } wr_t;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [31:0] cycles;
        int          run_len;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int tb_cyc   = 0;

    logic        start, start_to;
    logic        core_rst0, core_rst1;
    logic [31:0] core_pc0, core_pc1, core_gp0, core_gp1;
    logic        busy0, busy1, done0, done1, pass0, pass1, tmo0, tmo1;
    logic [31:0] cycles0, cycles1;

    int run_idx0 = 0, run_idx1 = 0;
    int halt0 = -1, halt1 = -1;
    int rst_hi0 = 0, rst_hi1 = 0, run_len0 = 0, run_len1 = 0;

    core_test_ctrl_if #(.ADDR_W(16)) bus0 ();
    core_test_ctrl_if #(.ADDR_W(16)) bus1 ();

    core_test_ctrl #(.TIMEOUT(5000), .RST_CYCLES(2), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus0), .core_rst(core_rst0),
        .core_pc(core_pc0), .core_gp(core_gp0), .busy(busy0), .done(done0),
        .pass(pass0), .timeout(tmo0), .cycles(cycles0)
    );

    core_test_ctrl #(.TIMEOUT(50), .RST_CYCLES(2), .ADDR_W(16)) dut_to (
        .clk(clk), .rst(rst), .start(start_to), .bus(bus1), .core_rst(core_rst1),
        .core_pc(core_pc1), .core_gp(core_gp1), .busy(busy1), .done(done1),
        .pass(pass1), .timeout(tmo1), .cycles(cycles1)
    );

    // Core model: counts its own cycles out of reset and jumps to the halt pc on cue.
    always @(posedge clk) begin
        tb_cyc++;
        run_idx0 <= core_rst0 ? 0 : run_idx0 + 1;
        run_idx1 <= core_rst1 ? 0 : run_idx1 + 1;
    end

    assign core_pc0 = (run_idx0 == halt0) ? 32'h44 : 32'h1000 + 32'(run_idx0) * 32'd4;
    assign core_pc1 = (run_idx1 == halt1) ? 32'h44 : 32'h1000 + 32'(run_idx1) * 32'd4;

    always @(negedge clk) begin
        if (busy0 && core_rst0)  rst_hi0++;
        if (busy0 && !core_rst0) run_len0++;
        if (busy1 && core_rst1)  rst_hi1++;
        if (busy1 && !core_rst1) run_len1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every mem_we pulse must match the oldest accepted write.
    always @(negedge clk) begin
        if (rst && bus0.mem_we) begin
            if (wr_q.size() == 0) begin
                check("mem_we unexpected", 32'(bus0.mem_we), 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("mem_addr", 32'(bus0.mem_addr), 32'(w.addr));
                check("mem_wdata", bus0.mem_wdata, w.data);
                check("mem_we latency", 32'(tb_cyc), 32'(w.due));
            end
        end
    end

    task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.due  = tb_cyc + 1;
        wr_q.push_back(w);
    endtask

    task automatic push_res(input logic p, input logic t, input logic [31:0] c, input int len);
        res_t r;
        r.pass = p;
        r.timeout = t;
        r.cycles = c;
        r.run_len = len;
        res_q.push_back(r);
    endtask

    task automatic do_run(input bit sel, input int budget);
        logic d;
        res_t r;
        d = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            d = sel ? done1 : done0;
            if (d) break;
        end
        check("done reached", 32'(d), 32'd1);
        r = res_q.pop_front();
        check("pass", 32'(sel ? pass1 : pass0), 32'(r.pass));
        check("timeout", 32'(sel ? tmo1 : tmo0), 32'(r.timeout));
        check("cycles", sel ? cycles1 : cycles0, r.cycles);
        check("run length", 32'(sel ? run_len1 : run_len0), 32'(r.run_len));
        check("core_rst high in RESET", 32'(sel ? rst_hi1 : rst_hi0), 32'd2);
        check("core_rst after done", 32'(sel ? core_rst1 : core_rst0), 32'd1);
        check("busy after done", 32'(sel ? busy1 : busy0), 32'd0);
    endtask

    initial begin
        logic reached;
        rst = 1'b0;
        start = 1'b0;
        start_to = 1'b0;
        core_gp0 = 32'h0;
        core_gp1 = 32'h0;
        bus0.load_valid = 1'b0;
        bus0.load_addr = '0;
        bus0.load_data = '0;
        bus1.load_valid = 1'b0;
        bus1.load_addr = '0;
        bus1.load_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset core_rst", 32'(core_rst0), 32'd1);
        check("reset load_ready", 32'(bus0.load_ready), 32'd1);
        check("reset done", 32'(done0), 32'd0);
        check("reset pass", 32'(pass0), 32'd0);
        check("reset timeout", 32'(tmo0), 32'd0);
        check("reset cycles", cycles0, 32'd0);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset mem_we", 32'(bus0.mem_we), 32'd0);
        @(negedge clk);

        $display("[TB] load burst");
        for (int i = 0; i < 4; i++) begin
            bus0.load_valid = 1'b1;
            bus0.load_addr = 16'(i);
            bus0.load_data = 32'h0000_0013;
            push_wr(16'(i), 32'h0000_0013);
            @(negedge clk);
        end
        bus0.load_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("burst drained", 32'(wr_q.size()), 32'd0);

        $display("[TB] pass run with load on start and refused load in RESET");
        halt0 = 100;
        core_gp0 = 32'h1;
        push_res(1'b1, 1'b0, 32'd100, 101);
        rst_hi0 = 0;
        run_len0 = 0;
        start = 1'b1;
        bus0.load_valid = 1'b1;
        bus0.load_addr = 16'h0004;
        bus0.load_data = 32'hDEAD_BEEF;
        push_wr(16'h0004, 32'hDEAD_BEEF);
        @(negedge clk);
        start = 1'b0;
        check("load_ready in RESET", 32'(bus0.load_ready), 32'd0);
        check("busy in RESET", 32'(busy0), 32'd1);
        bus0.load_addr = 16'h0055;
        bus0.load_data = 32'h5555_5555;
        @(negedge clk);
        check("mem_we refused in RESET", 32'(bus0.mem_we), 32'd0);
        bus0.load_valid = 1'b0;
        do_run(1'b0, 300);

        $display("[TB] fail run rerun from DONE");
        core_gp0 = 32'h5;
        push_res(1'b0, 1'b0, 32'd100, 101);
        rst_hi0 = 0;
        run_len0 = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rerun done cleared", 32'(done0), 32'd0);
        check("rerun pass cleared", 32'(pass0), 32'd0);
        do_run(1'b0, 300);

        $display("[TB] timeout run");
        halt1 = -1;
        core_gp1 = 32'h1;
        push_res(1'b0, 1'b1, 32'd49, 50);
        rst_hi1 = 0;
        run_len1 = 0;
        start_to = 1'b1;
        @(negedge clk);
        start_to = 1'b0;
        do_run(1'b1, 200);

        $display("[TB] halt on last budgeted cycle");
        halt1 = 49;
        push_res(1'b1, 1'b0, 32'd49, 50);
        rst_hi1 = 0;
        run_len1 = 0;
        start_to = 1'b1;
        @(negedge clk);
        start_to = 1'b0;
        check("rerun timeout cleared", 32'(tmo1), 32'd0);
        do_run(1'b1, 200);

        $display("[TB] async reset mid-RUN");
        halt0 = -1;
        core_gp0 = 32'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (run_idx0 == 20) begin
                reached = 1'b1;
                break;
            end
        end
        check("reached RUN cycle 20", 32'(reached), 32'd1);
        check("cycles at 20", cycles0, 32'd20);
        #2 rst = 1'b0;
        #1;
        check("async core_rst", 32'(core_rst0), 32'd1);
        check("async busy", 32'(busy0), 32'd0);
        check("async done", 32'(done0), 32'd0);
        check("async cycles", cycles0, 32'd0);
        check("async load_ready", 32'(bus0.load_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("no done after reset", 32'(done0), 32'd0);
        check("write queue empty", 32'(wr_q.size()), 32'd0);
        check("result queue empty", 32'(res_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
